// File: rtl/etpu_wb_feeder.sv
// etpu_wb_feeder: wishbone slave that queues packed int8 operand words and
// streams them, diagonally skewed, into the systolic array's 4-lane row input.
module etpu_wb_feeder #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DEPTH     = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] row_o,
    output logic        row_valid_o,
    input  logic        row_ready_i,
    output logic        clear_o
);
    localparam int NUM_LANES = 4;
    localparam int AW        = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [7:0]    remaining;
    logic [1:0]    drain_cnt;
    logic          ovf, done;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    // Byte offset bits carry no meaning for a word-wide register window.
    logic unused_adr;
    assign unused_adr = ^wbs_adr_i[1:0];

    // ---------------- bus decode ----------------
    logic       hit, req, wr;
    logic [1:0] off;
    logic       data_wr, ctrl_wr, stat_wr, clr, go;

    assign hit     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // Suppress a second ack while the first is still high (held strobe).
    assign req     = hit & ~wbs_ack_o;
    assign wr      = req & wbs_we_i;
    assign off     = wbs_adr_i[3:2];
    assign data_wr = wr & (off == 2'd0);
    assign ctrl_wr = wr & (off == 2'd1);
    assign stat_wr = wr & (off == 2'd2);
    assign clr     = ctrl_wr & wbs_dat_i[1];
    // CLR outranks GO; GO needs IDLE and a non-zero word count.
    assign go      = ctrl_wr & ~wbs_dat_i[1] & wbs_dat_i[0] &
                     (state_q == IDLE) & (wbs_dat_i[15:8] != 8'd0);

    // ---------------- FIFO ----------------
    logic        empty, full, advance, pop, push_ok;
    logic [31:0] push_word, head, src;

    assign empty   = (count == '0);
    assign full    = (count == FULL_LVL);
    assign advance = (((state_q == STREAM) & ~empty) | (state_q == DRAIN)) &
                     (~row_valid_o | row_ready_i);
    assign pop     = advance & (state_q == STREAM);
    assign push_ok = data_wr & (~full | pop);
    assign head    = mem[rd_ptr];
    // Drain beats inject zeros so the skew pipeline flushes cleanly.
    assign src     = (state_q == STREAM) ? head : 32'h0;

    // Byte-select masking of the pushed word.
    always_comb begin
        push_word = 32'h0;
        for (int i = 0; i < 4; i++)
            push_word[8*i +: 8] = wbs_sel_i[i] ? wbs_dat_i[8*i +: 8] : 8'h0;
    end

    // FIFO storage; no reset needed since occupancy is tracked by count.
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    // FIFO pointers and occupancy; CLR flushes.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
        end
    end

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Next-state: STREAM until the last word pops, then three drain beats.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = STREAM;
            STREAM:  if (pop && remaining == 8'd1) state_d = DRAIN;
            DRAIN:   if (advance && drain_cnt == 2'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) state_d = IDLE;
    end

    // Word/drain counters and sticky status bits.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            remaining <= 8'd0;
            drain_cnt <= 2'd0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else if (clr) begin
            remaining <= 8'd0;
            drain_cnt <= 2'd0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (go)       remaining <= wbs_dat_i[15:8];
            else if (pop) remaining <= remaining - 8'd1;

            if (pop && remaining == 8'd1)
                drain_cnt <= 2'd3;
            else if (state_q == DRAIN && advance)
                drain_cnt <= drain_cnt - 2'd1;

            if (state_q == DRAIN && advance && drain_cnt == 2'd1)
                done <= 1'b1;
            else if (go || (stat_wr && wbs_dat_i[2]))
                done <= 1'b0;

            if (data_wr && full && !pop)
                ovf <= 1'b1;
            else if (stat_wr && wbs_dat_i[1])
                ovf <= 1'b0;
        end
    end

    // ---------------- skew lanes ----------------
    // Lane k sees the source byte through k delay stages plus the output stage.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [7:0] out_q;
        if (k == 0) begin : g_direct
            // Lane 0 goes straight to the output register.
            always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
                if (!wb_rst_n_i)  out_q <= 8'h0;
                else if (clr)     out_q <= 8'h0;
                else if (advance) out_q <= src[7:0];
            end
        end else begin : g_delay
            logic [7:0] line_q [k];
            // Delay line shifts only on advance so a stall freezes the skew.
            always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
                if (!wb_rst_n_i) begin
                    out_q <= 8'h0;
                    for (int j = 0; j < k; j++) line_q[j] <= 8'h0;
                end else if (clr) begin
                    out_q <= 8'h0;
                    for (int j = 0; j < k; j++) line_q[j] <= 8'h0;
                end else if (advance) begin
                    out_q     <= line_q[k-1];
                    line_q[0] <= src[8*k +: 8];
                    for (int j = 1; j < k; j++) line_q[j] <= line_q[j-1];
                end
            end
        end
        assign row_o[8*k +: 8] = out_q;
    end

    // Row handshake: hold until taken, refill on every advance.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)      row_valid_o <= 1'b0;
        else if (clr)         row_valid_o <= 1'b0;
        else if (advance)     row_valid_o <= 1'b1;
        else if (row_ready_i) row_valid_o <= 1'b0;
    end

    // ---------------- bus response ----------------
    logic [31:0] status, rdata;
    assign status = {8'h00, remaining, 8'(count), 5'b0, done, ovf, (state_q != IDLE)};
    assign rdata  = (off == 2'd2) ? status : 32'h0;

    // Registered ack/read data sampled at the request cycle; clear pulse.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            clear_o   <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : 32'h0;
            clear_o   <= clr;
        end
    end
endmodule

// File: tb/tb_etpu_wb_feeder.sv
// Self-checking bench for etpu_wb_feeder: directed flow with random data,
// byte selects and backpressure, checked against a queue-based row model.
module tb_etpu_wb_feeder;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_DATA = BASE, A_CTRL = BASE + 4, A_STAT = BASE + 8, A_RSV = BASE + 12;
    localparam int DEPTH = 8;

    logic        clk = 0, rst_n = 0;
    logic        stb = 0, cyc = 0, we = 0, row_ready = 1;
    logic [3:0]  sel = 0;
    logic [31:0] adr = 0, dat_i = 0;
    logic        ack, row_valid, clear;
    logic [31:0] dat_o, row;

    etpu_wb_feeder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .row_o(row), .row_valid_o(row_valid), .row_ready_i(row_ready), .clear_o(clear)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int cyc_n = 0;
    int rdy_rand = 0;
    int clr_cnt = 0;
    logic [31:0] got[$];
    int          got_cyc[$];
    logic [31:0] mq[$];
    logic        stalled = 0;
    logic [31:0] held = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Beat collector and stall-hold checker, sampled mid-cycle.
    always @(negedge clk) begin
        if (clear) clr_cnt++;
        if (stalled && !clear && rst_n) begin
            check("hold_valid", {31'b0, row_valid}, 32'h1);
            check("hold_row", row, held);
        end
        stalled = row_valid && !row_ready;
        held = row;
        if (row_valid && row_ready) begin
            got.push_back(row);
            got_cyc.push_back(cyc_n);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        if (rdy_rand != 0) row_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output int lat);
        while (ack) tick();
        stb = 1; cyc = 1; we = w; adr = a; dat_i = d; sel = s; lat = 0;
        do begin tick(); lat++; end while (!ack && lat < 8);
        rd = dat_o;
        if (!ack) lat = -1;
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd; int lat;
        xfer(1'b1, a, d, s, rd, lat);
        check("wr_ack_lat", lat, 1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd; int lat;
        xfer(1'b0, a, 32'h0, 4'hF, rd, lat);
        check({tag, "_ack_lat"}, lat, 1);
        check(tag, rd, exp);
    endtask

    function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = 0;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Beat t, lane k carries byte k of word t-k; zero outside the word range.
    function automatic logic [31:0] exp_beat(input logic [31:0] ws[$], input int t);
        logic [31:0] r = 0, w;
        for (int k = 0; k < 4; k++) begin
            int i = t - k;
            if (i >= 0 && i < ws.size()) begin
                w = ws[i];
                r[8*k +: 8] = w[8*k +: 8];
            end
        end
        return r;
    endfunction

    task automatic push(input logic [31:0] d, input logic [3:0] s);
        wr(A_DATA, d, s);
        if (mq.size() < DEPTH) mq.push_back(mask(d, s));
    endtask

    task automatic take(input int n, output logic [31:0] ws[$]);
        ws = {};
        for (int i = 0; i < n; i++) ws.push_back(mq.pop_front());
    endtask

    task automatic go(input int n);
        wr(A_CTRL, {16'h0, 8'(n), 8'h01}, 4'hF);
    endtask

    task automatic wait_beats(input int n);
        int c = 0;
        while (got.size() < n && c < 400) begin tick(); c++; end
        check("beat_count", got.size(), n);
    endtask

    task automatic cmp_beats(input string tag, input logic [31:0] ws[$]);
        for (int t = 0; t < ws.size() + 3 && t < got.size(); t++)
            check($sformatf("%s_beat%0d", tag, t), got[t], exp_beat(ws, t));
    endtask

    task automatic clr_got();
        got.delete();
        got_cyc.delete();
    endtask

    initial begin
        logic [31:0] ws[$];
        logic [31:0] rdv;
        int lat, n, c0;

        // Reset / idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        tick();
        check("rst_ack", {31'b0, ack}, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_row", row, 32'h0);
        check("rst_valid", {31'b0, row_valid}, 32'h0);
        check("rst_clear", {31'b0, clear}, 32'h0);
        rd_chk("rst_status", A_STAT, 32'h0);
        rd_chk("rsv_read", A_RSV, 32'h0);

        // Basic skew with back-to-back beats
        clr_got();
        push(32'h0403_0201, 4'hF);
        push(32'h0807_0605, 4'hF);
        go(2);
        check("go_lat0", {31'b0, row_valid}, 32'h0);
        tick();
        check("go_lat1", {31'b0, row_valid}, 32'h1);
        wait_beats(5);
        take(2, ws);
        cmp_beats("basic", ws);
        if (got_cyc.size() == 5) check("b2b", got_cyc[4] - got_cyc[0], 4);
        rd_chk("basic_status", A_STAT, 32'h0000_0004);
        wr(A_STAT, 32'h4, 4'hF);
        rd_chk("done_w1c", A_STAT, 32'h0);

        // Backpressure: ready low for 3 cycles at beat 2
        clr_got();
        push(32'h0403_0201, 4'hF);
        push(32'h0807_0605, 4'hF);
        go(2);
        c0 = 0;
        while (got.size() < 2 && c0 < 50) begin tick(); c0++; end
        row_ready = 0;
        repeat (3) tick();
        check("bp_nolose", got.size(), 2);
        row_ready = 1;
        wait_beats(5);
        take(2, ws);
        cmp_beats("bp", ws);
        wr(A_STAT, 32'h4, 4'hF);

        // Overflow: 9 pushes into an 8-deep FIFO
        clr_got();
        for (int i = 0; i < 9; i++) push($urandom, 4'hF);
        rd_chk("ovf_status", A_STAT, 32'h0000_0802);
        wr(A_STAT, 32'h2, 4'hF);
        rd_chk("ovf_w1c", A_STAT, 32'h0000_0800);
        rdy_rand = 1;
        go(8);
        wait_beats(11);
        rdy_rand = 0; row_ready = 1;
        take(8, ws);
        cmp_beats("ovf", ws);
        rd_chk("ovf_done", A_STAT, 32'h0000_0004);
        wr(A_STAT, 32'h4, 4'hF);

        // Underflow stall
        clr_got();
        push($urandom, 4'(($urandom_range(0, 14)) + 1));
        go(3);
        repeat (10) tick();
        rd_chk("uf_status", A_STAT, 32'h0002_0001);
        check("uf_stall_beats", got.size(), 1);
        push($urandom, 4'hF);
        push($urandom, 4'(($urandom_range(0, 14)) + 1));
        wait_beats(6);
        take(3, ws);
        cmp_beats("uf", ws);
        wr(A_STAT, 32'h4, 4'hF);

        // CLR+GO mid-stream, then sel masking
        clr_got();
        for (int i = 0; i < 4; i++) push($urandom, 4'hF);
        row_ready = 0;
        go(4);
        repeat (3) tick();
        c0 = clr_cnt;
        wr(A_CTRL, 32'h0000_0203, 4'hF);
        check("clr_valid", {31'b0, row_valid}, 32'h0);
        repeat (3) tick();
        check("clr_pulse", clr_cnt - c0, 1);
        rd_chk("clr_status", A_STAT, 32'h0);
        mq.delete();
        push(32'hAABB_CCDD, 4'b0101);
        rd_chk("sel_level", A_STAT, 32'h0000_0100);
        row_ready = 1;
        clr_got();
        go(1);
        wait_beats(4);
        check("sel_word", got[0], 32'h0000_00DD);
        take(1, ws);
        cmp_beats("sel", ws);
        wr(A_STAT, 32'h4, 4'hF);

        // Random rounds with random selects and ready
        for (int r = 0; r < 3; r++) begin
            clr_got();
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) push($urandom, 4'($urandom_range(0, 15)));
            rdy_rand = 1;
            go(n);
            wait_beats(n + 3);
            rdy_rand = 0; row_ready = 1;
            take(n, ws);
            cmp_beats($sformatf("rnd%0d", r), ws);
            rd_chk("rnd_status", A_STAT, 32'h0000_0004);
            wr(A_STAT, 32'h4, 4'hF);
        end

        // Reserved write ignored, out-of-window never acked
        wr(A_RSV, 32'hFFFF_FFFF, 4'hF);
        rd_chk("rsv_nop", A_STAT, 32'h0);
        xfer(1'b1, BASE + 32'h10, 32'h0000_0201, 4'hF, rdv, lat);
        check("oow_noack", lat, -1);
        rd_chk("oow_nop", A_STAT, 32'h0);

        // Asynchronous reset mid-stream
        clr_got();
        for (int i = 0; i < 4; i++) push($urandom, 4'hF);
        row_ready = 0;
        go(4);
        repeat (2) tick();
        c0 = clr_cnt;
        rst_n = 0;
        #1;
        check("arst_valid", {31'b0, row_valid}, 32'h0);
        check("arst_row", row, 32'h0);
        check("arst_clear", {31'b0, clear}, 32'h0);
        tick();
        rst_n = 1;
        row_ready = 1;
        mq.delete();
        tick();
        check("arst_nopulse", clr_cnt - c0, 0);
        rd_chk("arst_status", A_STAT, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
